// File: rtl/sram_ctrl_pkg.sv
// Shared types and constants for the SRAM request controller slice.
package sram_ctrl_pkg;

  localparam int DEFAULT_WORD_SIZE = 8;
  localparam int DEFAULT_NUM_WORDS = 16;
  localparam int DEFAULT_ADDR_W    = $clog2(DEFAULT_NUM_WORDS);

  localparam logic CSB_IDLE = 1'b1;
  localparam logic WEB_IDLE = 1'b1;

  typedef logic [DEFAULT_ADDR_W-1:0]    addr_t;
  typedef logic [DEFAULT_WORD_SIZE-1:0] word_t;

  typedef struct packed {
    logic  we;
    addr_t addr;
    word_t wdata;
  } req_t;

endpackage

// File: rtl/sram_req_ctrl_if.sv
// Request/response streams plus macro pins; slave is the controller, master its surroundings.
interface sram_req_ctrl_if
  import sram_ctrl_pkg::*;
#(
  parameter int WORD_SIZE = DEFAULT_WORD_SIZE,
  parameter int ADDR_W    = DEFAULT_ADDR_W
);

  logic                 req_valid;
  logic                 req_ready;
  logic                 req_we;
  logic [ADDR_W-1:0]    req_addr;
  logic [WORD_SIZE-1:0] req_wdata;

  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [WORD_SIZE-1:0] rsp_rdata;

  logic [WORD_SIZE-1:0] din0;
  logic [ADDR_W-1:0]    addr0;
  logic                 csb0;
  logic                 web0;
  logic [WORD_SIZE-1:0] dout0;

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, rsp_ready, dout0,
    output req_ready, rsp_valid, rsp_rdata, din0, addr0, csb0, web0
  );

  modport master (
    output req_valid, req_we, req_addr, req_wdata, rsp_ready, dout0,
    input  req_ready, rsp_valid, rsp_rdata, din0, addr0, csb0, web0
  );

endinterface

// File: rtl/sram_rsp_fifo.sv
// Small synchronous FIFO buffering read data; pop side is valid/ready, push side is a plain enable.
module sram_rsp_fifo
  import sram_ctrl_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WORD_SIZE,
  parameter int DEPTH = 2,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] pushData_i,
  output logic             popValid_o,
  input  logic             popReady_i,
  output logic [WIDTH-1:0] popData_o,
  output logic [CNT_W-1:0] count_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wrPtr_q, rdPtr_q;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full, popFire, pushFire;

  assign full     = (count_q == CNT_W'(DEPTH));
  assign popFire  = popReady_i && (count_q != '0);
  assign pushFire = push_i && (!full || popFire);

  assign popValid_o = (count_q != '0);
  assign popData_o  = mem_q[rdPtr_q];
  assign count_o    = count_q;

  always_comb begin
    count_d = count_q;
    if (pushFire && !popFire) begin
      count_d = count_q + CNT_W'(1);
    end else if (!pushFire && popFire) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  // Storage needs no reset; occupancy alone decides what is visible.
  always_ff @(posedge clk_i) begin
    if (pushFire) begin
      mem_q[wrPtr_q] <= pushData_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      count_q <= count_d;
      if (pushFire) begin
        wrPtr_q <= (wrPtr_q == PTR_W'(DEPTH - 1)) ? '0 : wrPtr_q + PTR_W'(1);
      end
      if (popFire) begin
        rdPtr_q <= (rdPtr_q == PTR_W'(DEPTH - 1)) ? '0 : rdPtr_q + PTR_W'(1);
      end
    end
  end

  // Upstream credits must make an overflowing push impossible.
  assert property (@(posedge clk_i) disable iff (!rst_ni) !(push_i && full && !popFire));

endmodule

// File: rtl/sram_req_ctrl.sv
// Front-end for a single-port SRAM macro: registered pin timing, in-order read returns, credit flow control.
module sram_req_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int WORD_SIZE = DEFAULT_WORD_SIZE,
  parameter int NUM_WORDS = DEFAULT_NUM_WORDS,
  parameter int RD_LAT    = 1,
  parameter int RSP_DEPTH = 2
) (
  input logic            clk0,
  input logic            rstb0,
  sram_req_ctrl_if.slave bus
);

  localparam int ADDR_W = $clog2(NUM_WORDS);
  localparam int CNT_W  = $clog2(RSP_DEPTH + 1);

  logic                 acceptFire, readAccept, rspPop, rspPush;
  logic                 reqReady_q;
  logic [CNT_W-1:0]     credit_q, credit_d;
  logic [RD_LAT:0]      tag_q, tag_d;
  logic                 csb_q, web_q;
  logic [ADDR_W-1:0]    addr_q;
  logic [WORD_SIZE-1:0] din_q;
  logic [CNT_W-1:0]     fifoCount;

  assign acceptFire = bus.req_valid && reqReady_q;
  assign readAccept = acceptFire && !bus.req_we;
  assign rspPop     = bus.rsp_valid && bus.rsp_ready;
  assign rspPush    = tag_q[RD_LAT];

  assign bus.req_ready = reqReady_q;
  assign bus.csb0      = csb_q;
  assign bus.web0      = web_q;
  assign bus.addr0     = addr_q;
  assign bus.din0      = din_q;

  // Each read holds one credit from accept until its data leaves the FIFO.
  always_comb begin
    credit_d = credit_q;
    if (readAccept && !rspPop) begin
      credit_d = credit_q + CNT_W'(1);
    end else if (!readAccept && rspPop) begin
      credit_d = credit_q - CNT_W'(1);
    end
  end

  always_comb begin
    tag_d    = '0;
    tag_d[0] = readAccept;
    for (int i = 1; i <= RD_LAT; i++) begin
      tag_d[i] = tag_q[i-1];
    end
  end

  // Ready comes from next-cycle credits, so it only depends on state and rsp_ready.
  always_ff @(posedge clk0 or negedge rstb0) begin
    if (!rstb0) begin
      reqReady_q <= 1'b0;
      credit_q   <= '0;
      tag_q      <= '0;
      csb_q      <= CSB_IDLE;
      web_q      <= WEB_IDLE;
      addr_q     <= '0;
      din_q      <= '0;
    end else begin
      reqReady_q <= (credit_d < CNT_W'(RSP_DEPTH));
      credit_q   <= credit_d;
      tag_q      <= tag_d;
      if (acceptFire) begin
        csb_q  <= 1'b0;
        web_q  <= !bus.req_we;
        addr_q <= bus.req_addr;
        din_q  <= bus.req_we ? bus.req_wdata : '0;
      end else begin
        csb_q  <= CSB_IDLE;
        web_q  <= WEB_IDLE;
        addr_q <= '0;
        din_q  <= '0;
      end
    end
  end

  sram_rsp_fifo #(
    .WIDTH(WORD_SIZE),
    .DEPTH(RSP_DEPTH)
  ) u_rspFifo (
    .clk_i      (clk0),
    .rst_ni     (rstb0),
    .push_i     (rspPush),
    .pushData_i (bus.dout0),
    .popValid_o (bus.rsp_valid),
    .popReady_i (bus.rsp_ready),
    .popData_o  (bus.rsp_rdata),
    .count_o    (fifoCount)
  );

  assert property (@(posedge clk0) disable iff (!rstb0)
    int'(credit_q) == int'(fifoCount) + $countones(tag_q));

endmodule
